// File: rtl/gl_pkg.sv
// Shared types for the triangle assembler: vertex width, primitive-mode
// encodings, the assembled triangle type and the issue FSM states.
package gl_pkg;

    localparam int VERTEX_TYPE_SIZE = 96;

    typedef enum logic [1:0] {
        PRIM_TRIANGLES = 2'd0,
        PRIM_STRIP     = 2'd1,
        PRIM_FAN       = 2'd2,
        PRIM_RESERVED  = 2'd3
    } prim_mode_e;

    typedef logic [3*VERTEX_TYPE_SIZE-1:0] triangle_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } issue_state_e;

    // The reserved encoding assembles like plain triangles.
    function automatic prim_mode_e to_prim_mode(input logic [1:0] mode);
        case (mode)
            2'd1:    return PRIM_STRIP;
            2'd2:    return PRIM_FAN;
            default: return PRIM_TRIANGLES;
        endcase
    endfunction

endpackage

// File: rtl/gl_tri_fifo.sv
// Synchronous triangle FIFO; pointers carry an extra wrap bit so full and
// empty are told apart without a counter. Push is taken when full if a pop
// happens on the same edge.
module gl_tri_fifo #(
    parameter int WIDTH = 288,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic             wr_en_s, rd_en_s;

    assign empty    = (wr_q == rd_q);
    assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_data = mem_q[rd_q[AW-1:0]];
    assign wr_en_s  = push && (!full || pop);
    assign rd_en_s  = pop && !empty;

    // Next pointer values.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (wr_en_s) begin
            wr_d = wr_q + PTR_ONE;
        end else begin
            wr_d = wr_q;
        end
        if (rd_en_s) begin
            rd_d = rd_q + PTR_ONE;
        end else begin
            rd_d = rd_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/gl_triangle_assembler.sv
// Groups incoming vertices into triangles (list, strip, fan), queues them,
// and hands them one at a time to the rasterizer with an issue/done handshake.
module gl_triangle_assembler #(
    parameter int VERTEX_TYPE_SIZE = gl_pkg::VERTEX_TYPE_SIZE,
    parameter int TRI_FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        vtx_valid,
    output logic                        vtx_ready,
    input  logic [VERTEX_TYPE_SIZE-1:0] vtx_data,
    input  logic                        vtx_last,
    input  logic [1:0]                  prim_mode,
    output logic [VERTEX_TYPE_SIZE-1:0] fifo_in1,
    output logic [VERTEX_TYPE_SIZE-1:0] fifo_in2,
    output logic [VERTEX_TYPE_SIZE-1:0] fifo_in3,
    output logic                        fifo_ready,
    input  logic                        raster_ready,
    output logic                        busy
);
    import gl_pkg::*;

    localparam int VW = VERTEX_TYPE_SIZE;
    localparam int TW = 3 * VERTEX_TYPE_SIZE;

    logic          xfer_s, push_s, pop_s, full_s, empty_s;
    logic [TW-1:0] push_data_s, head_s;
    logic [1:0]    k_q, k_d;
    logic          parity_q, parity_d, first_q, first_d, rdy_q;
    prim_mode_e    mode_q, mode_d, cur_mode_s;
    logic [VW-1:0] a_q, a_d, b_q, b_d;
    issue_state_e  state_q, state_d;
    logic [VW-1:0] in1_q, in1_d, in2_q, in2_d, in3_q, in3_d;
    logic          fifo_ready_q, fifo_ready_d;

    // rdy_q keeps vtx_ready low until the first edge out of reset.
    assign vtx_ready  = rdy_q & ~full_s;
    assign xfer_s     = vtx_valid & vtx_ready;
    assign fifo_in1   = in1_q;
    assign fifo_in2   = in2_q;
    assign fifo_in3   = in3_q;
    assign fifo_ready = fifo_ready_q;
    assign busy       = ~empty_s | (state_q != ST_IDLE) | (k_q != 2'd0);

    gl_tri_fifo #(
        .WIDTH (TW),
        .DEPTH (TRI_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .pop_data  (head_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Vertex assembly: a/b hold the two vertices the next triangle is built from.
    always_comb begin
        k_d         = k_q;
        parity_d    = parity_q;
        first_d     = first_q;
        mode_d      = mode_q;
        a_d         = a_q;
        b_d         = b_q;
        push_s      = 1'b0;
        push_data_s = '0;
        if (first_q) begin
            cur_mode_s = to_prim_mode(prim_mode);
        end else begin
            cur_mode_s = mode_q;
        end
        if (xfer_s) begin
            mode_d   = cur_mode_s;
            first_d  = 1'b0;
            parity_d = ~parity_q;
            case (k_q)
                2'd0: begin
                    a_d = vtx_data;
                    k_d = 2'd1;
                end
                2'd1: begin
                    b_d = vtx_data;
                    k_d = 2'd2;
                end
                default: begin
                    push_s = 1'b1;
                    case (cur_mode_s)
                        PRIM_STRIP: begin
                            // Odd strip triangles swap the first two to keep winding.
                            if (parity_q) begin
                                push_data_s = {b_q, a_q, vtx_data};
                            end else begin
                                push_data_s = {a_q, b_q, vtx_data};
                            end
                            a_d = b_q;
                            b_d = vtx_data;
                        end
                        PRIM_FAN: begin
                            push_data_s = {a_q, b_q, vtx_data};
                            b_d         = vtx_data;
                        end
                        default: begin
                            push_data_s = {a_q, b_q, vtx_data};
                            k_d         = 2'd0;
                        end
                    endcase
                end
            endcase
            if (vtx_last) begin
                k_d      = 2'd0;
                parity_d = 1'b0;
                first_d  = 1'b1;
            end else begin
                first_d  = 1'b0;
            end
        end else begin
            k_d = k_q;
        end
    end

    // Assembly state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q      <= 2'd0;
            parity_q <= 1'b0;
            first_q  <= 1'b1;
            mode_q   <= PRIM_TRIANGLES;
            a_q      <= '0;
            b_q      <= '0;
            rdy_q    <= 1'b0;
        end else begin
            k_q      <= k_d;
            parity_q <= parity_d;
            first_q  <= first_d;
            mode_q   <= mode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rdy_q    <= 1'b1;
        end
    end

    // Issue FSM: load head, pulse fifo_ready once, hold until raster done.
    always_comb begin
        state_d = state_q;
        pop_s   = 1'b0;
        in1_d   = in1_q;
        in2_d   = in2_q;
        in3_d   = in3_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    in1_d   = head_s[TW-1:2*VW];
                    in2_d   = head_s[2*VW-1:VW];
                    in3_d   = head_s[VW-1:0];
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (raster_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        fifo_ready_d = (state_d == ST_ISSUE);
    end

    // Issue FSM and hold registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            in1_q        <= '0;
            in2_q        <= '0;
            in3_q        <= '0;
            fifo_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            in1_q        <= in1_d;
            in2_q        <= in2_d;
            in3_q        <= in3_d;
            fifo_ready_q <= fifo_ready_d;
        end
    end

endmodule
